// File: rtl/d_ff_pipe_en_pkg.sv
// -----------------------------------------------------------------------------
// d_ff_pipe_en_pkg
//   Shared defaults and types for the d_ff_pipe_en register pipeline.
//   DEF_WIDTH / DEF_DEPTH are the default word width and stage count used by
//   the pipeline and its stage sub-module; stage_act_e names the four things a
//   single stage can do on a clock edge.
// -----------------------------------------------------------------------------
package d_ff_pipe_en_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  // Per-stage edge action, listed in decreasing priority: reset, clear, load, hold.
  typedef enum logic [1:0] {
    ACT_HOLD  = 2'd0,
    ACT_CLEAR = 2'd1,
    ACT_LOAD  = 2'd2,
    ACT_RESET = 2'd3
  } stage_act_e;

endpackage

// File: rtl/d_ff_pipe_en_stage.sv
// -----------------------------------------------------------------------------
// d_ff_pipe_stage
//   One stage of the d_ff_pipe_en pipeline: a WIDTH-bit data register plus its
//   valid bit.
// Ports
//   clk       rising-edge clock
//   reset_n   synchronous active-low reset (valid=0, data=RESET_VAL)
//   load      take the upstream word/valid this edge
//   clear     drop the held word (valid=0, data holds)
//   up_valid  upstream valid bit
//   up_data   upstream data word
//   valid     registered valid bit
//   data      registered data word
// -----------------------------------------------------------------------------
module d_ff_pipe_stage
  import d_ff_pipe_en_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             clear,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  stage_act_e act;

  // NOTE: act gets a default before the priority chain so no path leaves it
  // unassigned; otherwise a latch would be inferred.
  always_comb begin
    act = ACT_HOLD;
    if (!reset_n)   act = ACT_RESET;
    else if (clear) act = ACT_CLEAR;
    else if (load)  act = ACT_LOAD;
  end

  // NOTE: non-blocking assignments keep every stage sampling the pre-edge
  // value of its neighbour, which is what makes the words shift rather than
  // fall through the whole pipe in one edge.
  always_ff @(posedge clk) begin
    case (act)
      ACT_RESET: begin
        valid <= 1'b0;
        data  <= RESET_VAL;
      end
      ACT_CLEAR: valid <= 1'b0;
      ACT_LOAD: begin
        valid <= up_valid;
        // A bubble moving in only clears valid; the old data stays put.
        if (up_valid) data <= up_data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/d_ff_pipe_en.sv
// -----------------------------------------------------------------------------
// d_ff_pipe_en
//   Elastic register pipeline: DEPTH stages of WIDTH-bit registers with a
//   global enable, synchronous flush and valid/ready handshakes on both ends.
//   Empty-pipe latency is DEPTH clocks, throughput one word per clock, and
//   bubbles collapse because every stage may load whenever its downstream
//   neighbour is empty or moving.
// Ports
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset
//   en         global enable, 0 freezes all state and blocks both handshakes
//   flush      drop all in-flight words on the next edge
//   in_valid   producer offers in_data
//   in_ready   pipe accepts in_data this cycle
//   in_data    input word
//   out_valid  out_data holds a valid word
//   out_ready  consumer takes out_data this cycle
//   out_data   output word (last stage register)
//   occupancy  number of valid words held
// -----------------------------------------------------------------------------
module d_ff_pipe_en
  import d_ff_pipe_en_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               DEPTH     = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              OCC_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q   [DEPTH];
  logic [DEPTH-1:0] up_valid;
  logic [WIDTH-1:0] up_data  [DEPTH];
  logic [DEPTH:0]   rdy;
  logic             in_fire;
  logic             out_fire;

  // A stage can take a word if it is empty or its own word moves on this edge;
  // the chain is evaluated from the consumer back to the producer.
  assign rdy[DEPTH] = out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    assign rdy[i] = ~valid_q[i] | rdy[i+1];

    if (i == 0) begin : g_head
      assign up_valid[i] = in_valid;
      assign up_data[i]  = in_data;
    end else begin : g_body
      assign up_valid[i] = valid_q[i-1];
      assign up_data[i]  = data_q[i-1];
    end

    d_ff_pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (en & rdy[i]),
      .clear    (flush),
      .up_valid (up_valid[i]),
      .up_data  (up_data[i]),
      .valid    (valid_q[i]),
      .data     (data_q[i])
    );
  end

  // Both handshakes are masked during flush, while disabled and while in reset,
  // so the occupancy count only ever sees transfers that really happen.
  assign in_ready  = en & ~flush & reset_n & rdy[0];
  assign out_valid = en & ~flush & reset_n & valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

  assign in_fire  = in_valid  & in_ready;
  assign out_fire = out_valid & out_ready;

  // Simultaneous accept and deliver leave the count unchanged.
  always_ff @(posedge clk) begin
    if (!reset_n)                 occupancy <= '0;
    else if (flush)               occupancy <= '0;
    else if (in_fire & ~out_fire) occupancy <= occupancy + OCC_W'(1);
    else if (out_fire & ~in_fire) occupancy <= occupancy - OCC_W'(1);
  end

endmodule

// File: tb/tb_d_ff_pipe_en.sv
// -----------------------------------------------------------------------------
// tb_d_ff_pipe_en
//   Directed bench for d_ff_pipe_en (WIDTH=8, DEPTH=4, RESET_VAL=0).
//   Each vector drives the inputs just after a falling edge and compares the
//   outputs 1ns later, i.e. the state left by the previous rising edge
//   combined with the current inputs.
// -----------------------------------------------------------------------------
module tb_d_ff_pipe_en;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset_n;
  logic             en;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [OCC_W-1:0] occupancy;

  int checks   = 0;
  int failures = 0;

  always #10 clk = ~clk;

  d_ff_pipe_en #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .RESET_VAL (8'h00)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  // Inputs, then expected outputs. cd=1 means out_data is compared too.
  typedef struct {
    logic             rst_n;
    logic             en;
    logic             fl;
    logic             iv;
    logic [WIDTH-1:0] id;
    logic             ordy;
    logic             e_ir;
    logic             e_ov;
    logic [WIDTH-1:0] e_od;
    logic             cd;
    logic [OCC_W-1:0] e_occ;
  } vec_t;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    @(negedge clk);
    reset_n   = v.rst_n;
    en        = v.en;
    flush     = v.fl;
    in_valid  = v.iv;
    in_data   = v.id;
    out_ready = v.ordy;
    #1;
    check({tag, ".in_ready"},  8'(in_ready),  8'(v.e_ir));
    check({tag, ".out_valid"}, 8'(out_valid), 8'(v.e_ov));
    check({tag, ".occupancy"}, 8'(occupancy), 8'(v.e_occ));
    if (v.cd) check({tag, ".out_data"}, out_data, v.e_od);
  endtask

  vec_t tbl [19];

  initial begin
    // rst en fl iv  id    ordy | ir ov od    cd occ
    // 1: reset with a word offered
    tbl[0]  = '{0, 1, 0, 1, 8'hFF, 1,  0, 0, 8'h00, 1, 0};
    tbl[1]  = '{0, 1, 0, 1, 8'hFF, 1,  0, 0, 8'h00, 1, 0};
    // 2: single word through an empty pipe, out after 4 edges
    tbl[2]  = '{1, 1, 0, 1, 8'hA5, 1,  1, 0, 8'h00, 0, 0};
    tbl[3]  = '{1, 1, 0, 0, 8'h00, 1,  1, 0, 8'h00, 0, 1};
    tbl[4]  = '{1, 1, 0, 0, 8'h00, 1,  1, 0, 8'h00, 0, 1};
    tbl[5]  = '{1, 1, 0, 0, 8'h00, 1,  1, 0, 8'h00, 0, 1};
    tbl[6]  = '{1, 1, 0, 0, 8'h00, 1,  1, 1, 8'hA5, 1, 1};
    tbl[7]  = '{1, 1, 0, 0, 8'h00, 0,  1, 0, 8'h00, 0, 0};
    // 3: fill with out_ready=0, then drain with same-cycle refill
    tbl[8]  = '{1, 1, 0, 1, 8'h01, 0,  1, 0, 8'h00, 0, 0};
    tbl[9]  = '{1, 1, 0, 1, 8'h02, 0,  1, 0, 8'h00, 0, 1};
    tbl[10] = '{1, 1, 0, 1, 8'h03, 0,  1, 0, 8'h00, 0, 2};
    tbl[11] = '{1, 1, 0, 1, 8'h04, 0,  1, 0, 8'h00, 0, 3};
    tbl[12] = '{1, 1, 0, 1, 8'h05, 0,  0, 1, 8'h01, 1, 4};
    tbl[13] = '{1, 1, 0, 1, 8'h05, 1,  1, 1, 8'h01, 1, 4};
    tbl[14] = '{1, 1, 0, 0, 8'h00, 1,  1, 1, 8'h02, 1, 4};
    tbl[15] = '{1, 1, 0, 0, 8'h00, 1,  1, 1, 8'h03, 1, 3};
    tbl[16] = '{1, 1, 0, 0, 8'h00, 1,  1, 1, 8'h04, 1, 2};
    tbl[17] = '{1, 1, 0, 0, 8'h00, 1,  1, 1, 8'h05, 1, 1};
    tbl[18] = '{1, 1, 0, 0, 8'h00, 1,  1, 0, 8'h00, 0, 0};

    // One reset edge first so the table starts from a known state.
    reset_n   = 1'b0;
    en        = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hFF;
    out_ready = 1'b1;
    @(posedge clk);

    for (int i = 0; i < 19; i++) run_vec($sformatf("tbl%0d", i), tbl[i]);

    // 4: freeze a full pipe for three cycles with en=0
    run_vec("en.a", '{1, 1, 0, 1, 8'h31, 1,  1, 0, 8'h00, 0, 0});
    run_vec("en.b", '{1, 1, 0, 1, 8'h32, 1,  1, 0, 8'h00, 0, 1});
    run_vec("en.c", '{1, 1, 0, 1, 8'h33, 1,  1, 0, 8'h00, 0, 2});
    run_vec("en.d", '{1, 1, 0, 1, 8'h34, 1,  1, 0, 8'h00, 0, 3});
    for (int i = 0; i < 3; i++)
      run_vec($sformatf("en.off%0d", i), '{1, 0, 0, 1, 8'h35, 1,  0, 0, 8'h31, 1, 4});
    run_vec("en.h", '{1, 1, 0, 1, 8'h35, 1,  1, 1, 8'h31, 1, 4});
    run_vec("en.i", '{1, 1, 0, 0, 8'h00, 1,  1, 1, 8'h32, 1, 4});
    run_vec("en.j", '{1, 1, 0, 0, 8'h00, 1,  1, 1, 8'h33, 1, 3});
    run_vec("en.k", '{1, 1, 0, 0, 8'h00, 1,  1, 1, 8'h34, 1, 2});
    run_vec("en.l", '{1, 1, 0, 0, 8'h00, 1,  1, 1, 8'h35, 1, 1});
    run_vec("en.m", '{1, 1, 0, 0, 8'h00, 1,  1, 0, 8'h00, 0, 0});

    // 5: flush three words (one already at the output) while 77 is offered
    run_vec("fl.a", '{1, 1, 0, 1, 8'h41, 0,  1, 0, 8'h00, 0, 0});
    run_vec("fl.b", '{1, 1, 0, 1, 8'h42, 0,  1, 0, 8'h00, 0, 1});
    run_vec("fl.c", '{1, 1, 0, 1, 8'h43, 0,  1, 0, 8'h00, 0, 2});
    run_vec("fl.d", '{1, 1, 0, 0, 8'h00, 0,  1, 0, 8'h00, 0, 3});
    run_vec("fl.e", '{1, 1, 1, 1, 8'h77, 1,  0, 0, 8'h41, 1, 3});
    run_vec("fl.f", '{1, 1, 0, 0, 8'h00, 1,  1, 0, 8'h41, 1, 0});
    run_vec("fl.g", '{1, 1, 0, 1, 8'hA5, 1,  1, 0, 8'h00, 0, 0});
    run_vec("fl.h", '{1, 1, 0, 0, 8'h00, 1,  1, 0, 8'h00, 0, 1});
    run_vec("fl.i", '{1, 1, 0, 0, 8'h00, 1,  1, 0, 8'h00, 0, 1});
    run_vec("fl.j", '{1, 1, 0, 0, 8'h00, 1,  1, 0, 8'h00, 0, 1});
    run_vec("fl.k", '{1, 1, 0, 0, 8'h00, 1,  1, 1, 8'hA5, 1, 1});
    run_vec("fl.l", '{1, 1, 0, 0, 8'h00, 1,  1, 0, 8'h00, 0, 0});

    // 6: bubble collapse under a stalled consumer, then back-to-back drain
    run_vec("bc.0", '{1, 1, 0, 1, 8'h10, 0,  1, 0, 8'h00, 0, 0});
    run_vec("bc.1", '{1, 1, 0, 0, 8'h00, 0,  1, 0, 8'h00, 0, 1});
    run_vec("bc.2", '{1, 1, 0, 1, 8'h20, 0,  1, 0, 8'h00, 0, 1});
    run_vec("bc.3", '{1, 1, 0, 0, 8'h00, 0,  1, 0, 8'h00, 0, 2});
    run_vec("bc.4", '{1, 1, 0, 0, 8'h00, 0,  1, 1, 8'h10, 1, 2});
    run_vec("bc.5", '{1, 1, 0, 0, 8'h00, 0,  1, 1, 8'h10, 1, 2});
    run_vec("bc.6", '{1, 1, 0, 0, 8'h00, 1,  1, 1, 8'h10, 1, 2});
    run_vec("bc.7", '{1, 1, 0, 0, 8'h00, 1,  1, 1, 8'h20, 1, 1});
    run_vec("bc.8", '{1, 1, 0, 0, 8'h00, 1,  1, 0, 8'h00, 0, 0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
